// File: rtl/ifu_fetch_ctrl.sv
// Fetch controller: owns the fetch PC, keeps one i-cache request in flight,
// squashes stale responses on redirect and walks an i-cache invalidate on fence.i.
module ifu_fetch_ctrl #(
   parameter logic [31:0] RESET_PC     = 32'h8000_0000,
   parameter int unsigned ICACHE_LINES = 16,
   parameter int unsigned IDX_W        = $clog2(ICACHE_LINES)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [31:0]      dnpc,
   input  logic             dnpc_flag,
   input  logic             icache_clr,
   output logic             if_req_valid,
   output logic [31:0]      if_req_addr,
   input  logic             if_req_ready,
   input  logic             if_rsp_valid,
   input  logic [31:0]      if_rsp_inst,
   output logic             inst_valid,
   output logic [31:0]      inst,
   output logic [31:0]      inst_pc,
   input  logic             idu_ready,
   output logic             inv_valid,
   output logic [IDX_W-1:0] inv_index,
   output logic             flush_busy
);

   typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DRAIN, S_FLUSH} state_e;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ICACHE_LINES - 1);

   state_e           state_q;
   logic [31:0]      pc_q;
   logic [31:0]      pc_d;
   logic [31:0]      req_pc_q;
   logic [31:0]      inst_q;
   logic [31:0]      inst_pc_q;
   logic             inst_valid_q;
   logic             squash_q;
   logic             inv_valid_q;
   logic [IDX_W-1:0] inv_index_q;
   logic             flush_busy_q;

   logic buf_free;
   logic req_fire;
   logic rsp_load;
   logic fetch_pending;

   assign buf_free = !inst_valid_q || idu_ready;

   // Gated by reset so no request is visible while reset is held.
   assign if_req_valid = reset && (state_q == S_FETCH) && buf_free
                         && !dnpc_flag && !icache_clr;
   assign req_fire     = if_req_valid && if_req_ready;
   assign rsp_load     = (state_q == S_WAIT) && if_rsp_valid && !squash_q
                         && !dnpc_flag && !icache_clr;
   // A response arriving this very cycle retires the outstanding fetch.
   assign fetch_pending = ((state_q == S_WAIT) || (state_q == S_DRAIN)) && !if_rsp_valid;

   always_comb begin
      pc_d = pc_q;
      if (dnpc_flag) begin
         pc_d = dnpc;
      end else if (req_fire) begin
         pc_d = pc_q + 32'd4;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= S_FETCH;
         pc_q         <= RESET_PC;
         req_pc_q     <= '0;
         inst_q       <= '0;
         inst_pc_q    <= '0;
         inst_valid_q <= 1'b0;
         squash_q     <= 1'b0;
         inv_valid_q  <= 1'b0;
         inv_index_q  <= '0;
         flush_busy_q <= 1'b0;
      end else begin
         pc_q <= pc_d;
         if (req_fire) begin
            req_pc_q <= pc_q;
         end

         if (dnpc_flag || icache_clr) begin
            inst_valid_q <= 1'b0;
         end else if (rsp_load) begin
            inst_valid_q <= 1'b1;
            inst_q       <= if_rsp_inst;
            inst_pc_q    <= req_pc_q;
         end else if (idu_ready) begin
            inst_valid_q <= 1'b0;
         end

         if (icache_clr) begin
            flush_busy_q <= 1'b1;
            inv_index_q  <= '0;
            if (fetch_pending) begin
               state_q     <= S_DRAIN;
               squash_q    <= 1'b1;
               inv_valid_q <= 1'b0;
            end else begin
               state_q     <= S_FLUSH;
               squash_q    <= 1'b0;
               inv_valid_q <= 1'b1;
            end
         end else begin
            case (state_q)
               S_FETCH: begin
                  if (req_fire) begin
                     state_q <= S_WAIT;
                  end
               end
               S_WAIT: begin
                  if (if_rsp_valid) begin
                     state_q  <= S_FETCH;
                     squash_q <= 1'b0;
                  end else if (dnpc_flag) begin
                     squash_q <= 1'b1;
                  end
               end
               S_DRAIN: begin
                  if (if_rsp_valid) begin
                     state_q     <= S_FLUSH;
                     squash_q    <= 1'b0;
                     inv_valid_q <= 1'b1;
                     inv_index_q <= '0;
                  end
               end
               S_FLUSH: begin
                  if (inv_index_q == LAST_IDX) begin
                     state_q      <= S_FETCH;
                     inv_valid_q  <= 1'b0;
                     inv_index_q  <= '0;
                     flush_busy_q <= 1'b0;
                  end else begin
                     inv_index_q <= inv_index_q + 1'b1;
                  end
               end
            endcase
         end
      end
   end

   assign if_req_addr = pc_q;
   assign inst_valid  = inst_valid_q;
   assign inst        = inst_q;
   assign inst_pc     = inst_pc_q;
   assign inv_valid   = inv_valid_q;
   assign inv_index   = inv_index_q;
   assign flush_busy  = flush_busy_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl: vector table for fetch/redirect traffic,
// hand sequences for the invalidate walk, walk restart and reset mid-walk.
module tb_ifu_fetch_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] dnpc;
   logic        dnpc_flag;
   logic        icache_clr;
   logic        if_req_valid;
   logic [31:0] if_req_addr;
   logic        if_req_ready;
   logic        if_rsp_valid;
   logic [31:0] if_rsp_inst;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        idu_ready;
   logic        inv_valid;
   logic [3:0]  inv_index;
   logic        flush_busy;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   always #5 clock = ~clock;

   ifu_fetch_ctrl #(
      .RESET_PC     (32'h8000_0000),
      .ICACHE_LINES (16)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .dnpc         (dnpc),
      .dnpc_flag    (dnpc_flag),
      .icache_clr   (icache_clr),
      .if_req_valid (if_req_valid),
      .if_req_addr  (if_req_addr),
      .if_req_ready (if_req_ready),
      .if_rsp_valid (if_rsp_valid),
      .if_rsp_inst  (if_rsp_inst),
      .inst_valid   (inst_valid),
      .inst         (inst),
      .inst_pc      (inst_pc),
      .idu_ready    (idu_ready),
      .inv_valid    (inv_valid),
      .inv_index    (inv_index),
      .flush_busy   (flush_busy)
   );

   typedef struct {
      logic        df;
      logic [31:0] dn;
      logic        rdy;
      logic        rv;
      logic [31:0] ri;
      logic        idu;
      logic        e_rv;
      logic [31:0] e_addr;
      logic        e_iv;
      logic [31:0] e_inst;
      logic [31:0] e_ipc;
   } vec_t;

   function automatic vec_t mk(input logic df, input logic [31:0] dn, input logic rdy,
                               input logic rv, input logic [31:0] ri, input logic idu,
                               input logic e_rv, input logic [31:0] e_addr, input logic e_iv,
                               input logic [31:0] e_inst, input logic [31:0] e_ipc);
      vec_t v;
      v.df = df; v.dn = dn; v.rdy = rdy; v.rv = rv; v.ri = ri; v.idu = idu;
      v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_inst = e_inst; v.e_ipc = e_ipc;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic df, input logic [31:0] dn, input logic clr, input logic rdy,
                         input logic rv, input logic [31:0] ri, input logic idu);
      dnpc_flag = df; dnpc = dn; icache_clr = clr; if_req_ready = rdy;
      if_rsp_valid = rv; if_rsp_inst = ri; idu_ready = idu;
   endtask

   // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
   task automatic cyc(input logic df, input logic [31:0] dn, input logic clr, input logic rdy,
                      input logic rv, input logic [31:0] ri, input logic idu);
      @(posedge clock);
      #1;
      set_in(df, dn, clr, rdy, rv, ri, idu);
      @(negedge clock);
   endtask

   vec_t tbl[24];

   initial begin
      tbl[0]  = mk(0, 0,            1, 0, 0,            1, 1, 32'h8000_0000, 0, 0,            0);
      tbl[1]  = mk(0, 0,            1, 1, 32'h13,       1, 0, 32'h8000_0004, 0, 0,            0);
      tbl[2]  = mk(0, 0,            1, 0, 0,            0, 0, 32'h8000_0004, 1, 32'h13,       32'h8000_0000);
      tbl[3]  = mk(0, 0,            1, 0, 0,            0, 0, 32'h8000_0004, 1, 32'h13,       32'h8000_0000);
      tbl[4]  = mk(0, 0,            1, 0, 0,            1, 1, 32'h8000_0004, 1, 32'h13,       32'h8000_0000);
      tbl[5]  = mk(0, 0,            1, 1, 32'h0010_0093, 1, 0, 32'h8000_0008, 0, 32'h13,      32'h8000_0000);
      tbl[6]  = mk(0, 0,            0, 0, 0,            0, 0, 32'h8000_0008, 1, 32'h0010_0093, 32'h8000_0004);
      tbl[7]  = mk(0, 0,            0, 0, 0,            1, 1, 32'h8000_0008, 1, 32'h0010_0093, 32'h8000_0004);
      tbl[8]  = mk(0, 0,            0, 0, 0,            1, 1, 32'h8000_0008, 0, 32'h0010_0093, 32'h8000_0004);
      tbl[9]  = mk(0, 0,            1, 0, 0,            1, 1, 32'h8000_0008, 0, 32'h0010_0093, 32'h8000_0004);
      tbl[10] = mk(1, 32'h8000_0100, 1, 0, 0,           1, 0, 32'h8000_000C, 0, 32'h0010_0093, 32'h8000_0004);
      tbl[11] = mk(0, 0,            1, 0, 0,            1, 0, 32'h8000_0100, 0, 32'h0010_0093, 32'h8000_0004);
      tbl[12] = mk(0, 0,            1, 1, 32'hDEAD_BEEF, 1, 0, 32'h8000_0100, 0, 32'h0010_0093, 32'h8000_0004);
      tbl[13] = mk(0, 0,            1, 0, 0,            1, 1, 32'h8000_0100, 0, 32'h0010_0093, 32'h8000_0004);
      tbl[14] = mk(1, 32'h8000_0200, 1, 1, 32'hCAFE_F00D, 1, 0, 32'h8000_0104, 0, 32'h0010_0093, 32'h8000_0004);
      tbl[15] = mk(0, 0,            1, 0, 0,            1, 1, 32'h8000_0200, 0, 32'h0010_0093, 32'h8000_0004);
      tbl[16] = mk(0, 0,            1, 1, 32'h517,      1, 0, 32'h8000_0204, 0, 32'h0010_0093, 32'h8000_0004);
      tbl[17] = mk(0, 0,            0, 0, 0,            1, 1, 32'h8000_0204, 1, 32'h517,      32'h8000_0200);
      tbl[18] = mk(1, 32'hFFFF_FFFC, 1, 0, 0,           1, 0, 32'h8000_0204, 0, 32'h517,      32'h8000_0200);
      tbl[19] = mk(0, 0,            1, 0, 0,            1, 1, 32'hFFFF_FFFC, 0, 32'h517,      32'h8000_0200);
      tbl[20] = mk(0, 0,            1, 1, 32'h8067,     1, 0, 32'h0000_0000, 0, 32'h517,      32'h8000_0200);
      tbl[21] = mk(0, 0,            1, 0, 0,            0, 0, 32'h0000_0000, 1, 32'h8067,     32'hFFFF_FFFC);
      tbl[22] = mk(1, 32'h8000_0000, 0, 0, 0,           0, 0, 32'h0000_0000, 1, 32'h8067,     32'hFFFF_FFFC);
      tbl[23] = mk(0, 0,            0, 0, 0,            0, 1, 32'h8000_0000, 0, 32'h8067,     32'hFFFF_FFFC);

      reset = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clock);
      chk("rst_req_valid", 32'(if_req_valid), 0);
      chk("rst_req_addr", if_req_addr, 32'h8000_0000);
      chk("rst_inst_valid", 32'(inst_valid), 0);
      chk("rst_inst", inst, 0);
      chk("rst_inst_pc", inst_pc, 0);
      chk("rst_inv_valid", 32'(inv_valid), 0);
      chk("rst_inv_index", 32'(inv_index), 0);
      chk("rst_flush_busy", 32'(flush_busy), 0);
      reset = 1'b1;

      for (int i = 0; i < 24; i++) begin
         cyc(tbl[i].df, tbl[i].dn, 1'b0, tbl[i].rdy, tbl[i].rv, tbl[i].ri, tbl[i].idu);
         chk($sformatf("v%0d_req_valid", i), 32'(if_req_valid), 32'(tbl[i].e_rv));
         chk($sformatf("v%0d_req_addr", i), if_req_addr, tbl[i].e_addr);
         chk($sformatf("v%0d_inst_valid", i), 32'(inst_valid), 32'(tbl[i].e_iv));
         chk($sformatf("v%0d_inst", i), inst, tbl[i].e_inst);
         chk($sformatf("v%0d_inst_pc", i), inst_pc, tbl[i].e_ipc);
         chk($sformatf("v%0d_inv_valid", i), 32'(inv_valid), 0);
         chk($sformatf("v%0d_flush_busy", i), 32'(flush_busy), 0);
      end

      // fence.i + redirect with a fetch outstanding: drain, then a full walk.
      cyc(0, 0, 0, 1, 0, 0, 1);
      chk("fl_req_valid", 32'(if_req_valid), 1);
      cyc(1, 32'h8000_0040, 1, 1, 0, 0, 1);
      chk("fl_clr_gate", 32'(if_req_valid), 0);
      for (int i = 0; i < 2; i++) begin
         cyc(0, 0, 0, 1, 0, 0, 1);
         chk("drain_busy", 32'(flush_busy), 1);
         chk("drain_inv", 32'(inv_valid), 0);
         chk("drain_req", 32'(if_req_valid), 0);
      end
      cyc(0, 0, 0, 1, 1, 32'h1111_1111, 1);
      chk("drain_rsp_inv", 32'(inv_valid), 0);
      for (int i = 0; i < 16; i++) begin
         cyc(0, 0, 0, 1, 0, 0, 1);
         chk("walk_inv_valid", 32'(inv_valid), 1);
         chk("walk_inv_index", 32'(inv_index), 32'(i));
         chk("walk_busy", 32'(flush_busy), 1);
         chk("walk_req", 32'(if_req_valid), 0);
         chk("walk_inst_valid", 32'(inst_valid), 0);
      end
      cyc(0, 0, 0, 0, 0, 0, 1);
      chk("walk_end_inv", 32'(inv_valid), 0);
      chk("walk_end_busy", 32'(flush_busy), 0);
      chk("walk_end_req", 32'(if_req_valid), 1);
      chk("walk_end_addr", if_req_addr, 32'h8000_0040);
      chk("walk_end_inst_valid", 32'(inst_valid), 0);

      // Walk restart on a second fence.i, with a redirect mid-walk.
      cyc(0, 0, 1, 0, 0, 0, 1);
      chk("rs_clr_gate", 32'(if_req_valid), 0);
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, (i == 4), 0, 0, 0, 1);
         chk("rs_pre_index", 32'(inv_index), 32'(i));
         chk("rs_pre_valid", 32'(inv_valid), 1);
      end
      for (int i = 0; i < 16; i++) begin
         cyc((i == 3), 32'h8000_0080, 0, 0, 0, 0, 1);
         chk("rs_index", 32'(inv_index), 32'(i));
         chk("rs_valid", 32'(inv_valid), 1);
      end
      cyc(0, 0, 0, 0, 0, 0, 1);
      chk("rs_end_inv", 32'(inv_valid), 0);
      chk("rs_end_busy", 32'(flush_busy), 0);
      chk("rs_end_req", 32'(if_req_valid), 1);
      chk("rs_end_addr", if_req_addr, 32'h8000_0080);

      // Reset in the middle of a walk.
      cyc(0, 0, 1, 0, 0, 0, 1);
      for (int i = 0; i < 8; i++) begin
         cyc(0, 0, 0, 0, 0, 0, 1);
         chk("mr_index", 32'(inv_index), 32'(i));
      end
      reset = 1'b0;
      #1;
      chk("mr_inv_valid", 32'(inv_valid), 0);
      chk("mr_inv_index", 32'(inv_index), 0);
      chk("mr_busy", 32'(flush_busy), 0);
      chk("mr_req_valid", 32'(if_req_valid), 0);
      chk("mr_req_addr", if_req_addr, 32'h8000_0000);
      chk("mr_inst_valid", 32'(inst_valid), 0);
      chk("mr_inst", inst, 0);
      chk("mr_inst_pc", inst_pc, 0);
      set_in(0, 0, 0, 0, 1, 32'hFFFF_FFFF, 1);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      @(negedge clock);
      chk("pr_inst_valid", 32'(inst_valid), 0);
      chk("pr_req_valid", 32'(if_req_valid), 1);
      chk("pr_req_addr", if_req_addr, 32'h8000_0000);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, 0, 0, 1);
         chk("pr_inv_valid", 32'(inv_valid), 0);
         chk("pr_busy", 32'(flush_busy), 0);
      end
      cyc(0, 0, 0, 1, 0, 0, 1);
      chk("pr_fetch_req", 32'(if_req_valid), 1);
      cyc(0, 0, 0, 0, 1, 32'h13, 1);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("pr_inst_valid2", 32'(inst_valid), 1);
      chk("pr_inst", inst, 32'h13);
      chk("pr_inst_pc", inst_pc, 32'h8000_0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
- Fetch-side consumer of the pipeline's redirect and i-cache-clear outputs (dnpc, dnpc_flag, icache_clr).
- Owns the architectural fetch PC and issues one outstanding instruction request at a time to the i-cache.
- Squashes in-flight fetches on redirect.
- Sequences a line-by-line i-cache invalidation walk on fence.i before fetch resumes.
- Sits between the i-cache and the IDU input register.

Parameters:
- RESET_PC, 32'h8000_0000, fetch PC after reset.
- ICACHE_LINES, 16, number of i-cache lines to invalidate; power of two, at least 2.
- IDX_W, $clog2(ICACHE_LINES), invalidate index width.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset; one clock.
- dnpc  in  32  redirect target PC.
- dnpc_flag  in  1  redirect strobe; dnpc valid this cycle.
- icache_clr  in  1  fence.i strobe; request a full i-cache invalidate.
- if_req_valid  out  1  fetch request valid.
- if_req_addr  out  32  fetch address; equals pc.
- if_req_ready  in  1  i-cache accepts the request.
- if_rsp_valid  in  1  fetch response valid; no backpressure.
- if_rsp_inst  in  32  fetched instruction.
- inst_valid  out  1  instruction buffer holds a valid instruction for the IDU.
- inst  out  32  buffered instruction.
- inst_pc  out  32  PC of the buffered instruction.
- idu_ready  in  1  IDU consumes the buffer this cycle.
- inv_valid  out  1  invalidate the i-cache line at inv_index this cycle.
- inv_index  out  IDX_W  line index being invalidated.
- flush_busy  out  1  high from the icache_clr capture until the walk completes.

Behaviour:
- Reset values (asynchronous, while reset = 0):
  - pc = RESET_PC, state = S_FETCH, squash = 0.
  - inst_valid = 0, inst = 0, inst_pc = 0.
  - inv_valid = 0, inv_index = 0, flush_busy = 0, if_req_valid = 0.
  - Reset mid-walk or mid-wait abandons everything; any response arriving after reset is ignored, because there is no outstanding request.
- States: S_FETCH, S_WAIT, S_DRAIN, S_FLUSH.
- S_FETCH:
  - if_req_valid = 1 only when the buffer is empty (inst_valid = 0, or idu_ready = 1 this cycle) and dnpc_flag = 0 and icache_clr = 0.
  - On if_req_valid & if_req_ready: latch req_pc = pc, pc += 4 (32-bit wrap at 0xFFFF_FFFC to 0), go to S_WAIT.
- S_WAIT:
  - On if_rsp_valid with squash = 0: buffer <= {inst = if_rsp_inst, inst_pc = req_pc}, inst_valid = 1, go to S_FETCH.
  - On if_rsp_valid with squash = 1: drop the response, clear squash, go to S_FETCH.
  - Minimum request-to-buffer latency is 1 cycle after the response.
- Buffer: inst_valid clears on idu_ready & inst_valid unless a new response loads in the same cycle.
- Redirect (dnpc_flag = 1, any state):
  - pc <= dnpc; inst_valid <= 0.
  - In S_WAIT, or a response arriving this same cycle: that response is discarded. Set squash = 1 if the response is still pending.
  - A request handshake in the same cycle cannot occur, because if_req_valid is gated.
- icache_clr = 1 (may coincide with dnpc_flag; the redirect still applies):
  - flush_busy <= 1, inst_valid <= 0.
  - If a fetch is outstanding: set squash, go to S_DRAIN, and wait for if_rsp_valid, which is dropped. Otherwise go to S_FLUSH.
- S_FLUSH:
  - inv_valid = 1 for exactly ICACHE_LINES consecutive cycles; inv_index counts 0 to ICACHE_LINES-1.
  - After index ICACHE_LINES-1: inv_valid = 0, flush_busy = 0, go to S_FETCH.
  - First new request is the next cycle, at the current pc.
- icache_clr during S_DRAIN/S_FLUSH: restart inv_index at 0; the walk length is again ICACHE_LINES from the restart.
- dnpc_flag during S_DRAIN/S_FLUSH: pc updates and the walk continues.
- No request is issued while flush_busy = 1.
- if_req_addr = pc at all times; only meaningful when if_req_valid = 1.

Test Plan:
- Reset release, if_req_ready = 1, response 1 cycle later with 0x00000013, idu_ready = 1 -> first req addr 0x80000000, then 0x80000004; inst = 0x00000013, inst_pc = 0x80000000.
- Hold idu_ready = 0 with the buffer full -> if_req_valid stays 0; buffer is stable. Raise idu_ready -> the next request issues in the same cycle.
- Redirect during S_WAIT: dnpc_flag with dnpc = 0x80000100; the stale response arrives 2 cycles later -> response dropped, inst_valid stays 0, next req addr 0x80000100.
- dnpc_flag coincident with if_rsp_valid -> response dropped; next req at dnpc.
- icache_clr + dnpc_flag (dnpc = 0x80000040) with a fetch outstanding -> S_DRAIN until the response, then inv_valid for 16 cycles, indices 0..15; flush_busy falls; next req 0x80000040.
- Drive reset low at inv_index = 7 -> all outputs reset immediately. After release, the first req is at 0x80000000 with no further inv_valid.
